// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings for the writeback scheduler
package wb_pkg;

  localparam int AW_DEF = 5;

  localparam logic [1:0] MD_F       = 2'd0;
  localparam logic [1:0] MD_DOUT    = 2'd1;
  localparam logic [1:0] MD_STATUS  = 2'd2;
  localparam logic [1:0] MD_PRODUCT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending product pair and RAW/WAW hazard detection
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] mul_da_i,
  input  logic          active_i,
  input  logic [AW-1:0] ex_sa_i,
  input  logic [AW-1:0] ex_sb_i,
  input  logic [AW-1:0] ex_da_i,
  input  logic          ex_rw_i,
  output logic          hazard_o,
  output logic [AW-1:0] lo_o
);

  logic [AW-1:0] lo_q, lo_d;
  logic [AW-1:0] hi_q, hi_d;
  logic          hit_sa, hit_sb, hit_da;

  // hi wraps modulo 2**AW, so the top register pairs with register 0
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (load_i) begin
      lo_d = mul_da_i;
      hi_d = mul_da_i + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  always_comb begin
    hit_sa   = (ex_sa_i == lo_q) || (ex_sa_i == hi_q);
    hit_sb   = (ex_sb_i == lo_q) || (ex_sb_i == hi_q);
    hit_da   = ex_rw_i && ((ex_da_i == lo_q) || (ex_da_i == hi_q));
    hazard_o = active_i && (hit_sa || hit_sb || hit_da);
  end

  assign lo_o = lo_q;

endmodule

// File: rtl/wb_scheduler.sv
// rtl/wb_scheduler.sv - arbitrates the register-file write port between
// the pipeline result and the multi-cycle multiplier product
module wb_scheduler
  import wb_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int AW      = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic          ex_rw,
  input  logic [1:0]    ex_md,
  input  logic [AW-1:0] ex_da,
  input  logic [AW-1:0] ex_sa,
  input  logic [AW-1:0] ex_sb,
  input  logic          mul_req,
  input  logic [AW-1:0] mul_da,
  output logic [1:0]    MD_1,
  output logic          RW,
  output logic [AW-1:0] DA,
  output logic          pair_wr,
  output logic          stall,
  output logic          mul_busy,
  output logic          illegal_md
);

  wb_state_e     state_q;
  logic [3:0]    cnt_q;
  logic          busy_any, in_ready, hazard, mul_accept, pipe_wr;
  logic [AW-1:0] lo;

  assign busy_any   = (state_q != IDLE);
  assign in_ready   = (state_q == READY);
  assign stall      = ex_valid && ((in_ready && ex_rw) || (mul_req && busy_any) || hazard);
  assign mul_accept = ex_valid && mul_req && !stall;
  assign pipe_wr    = ex_valid && ex_rw && !mul_req && !stall;
  assign mul_busy   = busy_any;

  wb_scoreboard #(.AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (mul_accept && (state_q == IDLE)),
    .mul_da_i (mul_da),
    .active_i (busy_any),
    .ex_sa_i  (ex_sa),
    .ex_sb_i  (ex_sb),
    .ex_da_i  (ex_da),
    .ex_rw_i  (ex_rw),
    .hazard_o (hazard),
    .lo_o     (lo)
  );

  // Counter is loaded with MUL_LAT-1 and READY follows the cycle it reads 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mul_accept) begin
            state_q <= BUSY;
            cnt_q   <= 4'(MUL_LAT - 1);
          end
        end
        BUSY: begin
          if (cnt_q == 4'd1) begin
            state_q <= READY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        READY:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    MD_1       = MD_F;
    RW         = 1'b0;
    DA         = '0;
    pair_wr    = 1'b0;
    illegal_md = 1'b0;
    if (in_ready) begin
      MD_1    = MD_PRODUCT;
      RW      = 1'b1;
      DA      = lo;
      pair_wr = 1'b1;
    end else if (pipe_wr) begin
      if (ex_md == MD_PRODUCT) begin
        illegal_md = 1'b1;
      end else begin
        MD_1 = ex_md;
        RW   = 1'b1;
        DA   = ex_da;
      end
    end
  end

endmodule

// File: tb/tb_wb_scheduler.sv
// tb/tb_wb_scheduler.sv - directed scoreboard bench for wb_scheduler
module tb_wb_scheduler;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 1'b0, ex_rw = 1'b0, mul_req = 1'b0;
  logic [1:0]    ex_md = 2'd0;
  logic [AW-1:0] ex_da = '0, ex_sa = '0, ex_sb = '0, mul_da = '0;
  logic [1:0]    MD_1;
  logic          RW, pair_wr, stall, mul_busy, illegal_md;
  logic [AW-1:0] DA;

  logic [11:0]   exp_q[$];
  string         name_q[$];
  int            total = 0, bad = 0;
  logic [11:0]   exp_v, act_v;
  string         exp_n;

  always #5 clk = ~clk;

  wb_scheduler #(.MUL_LAT(4), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_md(ex_md),
    .ex_da(ex_da), .ex_sa(ex_sa), .ex_sb(ex_sb), .mul_req(mul_req), .mul_da(mul_da),
    .MD_1(MD_1), .RW(RW), .DA(DA), .pair_wr(pair_wr), .stall(stall),
    .mul_busy(mul_busy), .illegal_md(illegal_md)
  );

  function automatic logic [11:0] ev(input logic [1:0] md, input logic rw, input logic [4:0] da,
                                     input logic pr, input logic st, input logic bz, input logic il);
    return {md, rw, da, pr, st, bz, il};
  endfunction

  task automatic step(input string nm, input logic rn, input logic v, input logic rw,
                      input logic [1:0] md, input logic [4:0] da, input logic [4:0] sa,
                      input logic [4:0] sb, input logic mr, input logic [4:0] mda,
                      input logic [11:0] e);
    @(posedge clk);
    #1;
    rst_n = rn; ex_valid = v; ex_rw = rw; ex_md = md; ex_da = da;
    ex_sa = sa; ex_sb = sb; mul_req = mr; mul_da = mda;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      exp_n = name_q.pop_front();
      act_v = {MD_1, RW, DA, pair_wr, stall, mul_busy, illegal_md};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s: got md=%0d rw=%0d da=%0d pair=%0d stall=%0d busy=%0d ill=%0d want md=%0d rw=%0d da=%0d pair=%0d stall=%0d busy=%0d ill=%0d",
                 exp_n, act_v[11:10], act_v[9], act_v[8:4], act_v[3], act_v[2], act_v[1], act_v[0],
                 exp_v[11:10], exp_v[9], exp_v[8:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name         rn v rw md da  sa sb mr mda  expected md rw da pr st bz il
    step("reset",       0, 0, 0, 0, 0,  0, 0, 0, 0,  ev(0, 0, 0,  0, 0, 0, 0));
    step("idle",        1, 0, 0, 0, 0,  0, 0, 0, 0,  ev(0, 0, 0,  0, 0, 0, 0));
    step("alu_r7",      1, 1, 1, 0, 7,  1, 2, 0, 0,  ev(0, 1, 7,  0, 0, 0, 0));
    step("dout_r8",     1, 1, 1, 1, 8,  1, 2, 0, 0,  ev(1, 1, 8,  0, 0, 0, 0));
    step("nowrite",     1, 1, 0, 2, 9,  1, 2, 0, 0,  ev(0, 0, 0,  0, 0, 0, 0));
    // multiply to r10/r11, product in the fourth cycle after acceptance
    step("mul_acc",     1, 1, 0, 0, 0,  1, 2, 1, 10, ev(0, 0, 0,  0, 0, 0, 0));
    step("busy_c1",     1, 0, 0, 0, 0,  0, 0, 0, 0,  ev(0, 0, 0,  0, 0, 1, 0));
    step("busy_status", 1, 1, 1, 2, 4,  1, 2, 0, 0,  ev(2, 1, 4,  0, 0, 1, 0));
    step("busy_c3",     1, 0, 0, 0, 0,  0, 0, 0, 0,  ev(0, 0, 0,  0, 0, 1, 0));
    step("ready_coll",  1, 1, 1, 0, 3,  1, 2, 0, 0,  ev(3, 1, 10, 1, 1, 1, 0));
    step("retry_r3",    1, 1, 1, 0, 3,  1, 2, 0, 0,  ev(0, 1, 3,  0, 0, 0, 0));
    // wrap-around pair r31/r0
    step("mul31",       1, 1, 0, 0, 0,  1, 2, 1, 31, ev(0, 0, 0,  0, 0, 0, 0));
    step("haz_sa0",     1, 1, 0, 0, 0,  0, 2, 0, 0,  ev(0, 0, 0,  0, 1, 1, 0));
    step("sa5_ok",      1, 1, 0, 0, 0,  5, 2, 0, 0,  ev(0, 0, 0,  0, 0, 1, 0));
    step("waw_r31",     1, 1, 1, 0, 31, 5, 6, 0, 0,  ev(0, 0, 0,  0, 1, 1, 0));
    step("ready_haz",   1, 1, 0, 0, 0,  0, 2, 0, 0,  ev(3, 1, 31, 1, 1, 1, 0));
    step("post_sa0",    1, 1, 0, 0, 0,  0, 2, 0, 0,  ev(0, 0, 0,  0, 0, 0, 0));
    // second multiply held off while the first is in flight
    step("mul12",       1, 1, 0, 0, 0,  1, 2, 1, 12, ev(0, 0, 0,  0, 0, 0, 0));
    step("mul2_b1",     1, 1, 0, 0, 0,  1, 2, 1, 20, ev(0, 0, 0,  0, 1, 1, 0));
    step("mul2_b2",     1, 1, 0, 0, 0,  1, 2, 1, 20, ev(0, 0, 0,  0, 1, 1, 0));
    step("mul2_b3",     1, 1, 0, 0, 0,  1, 2, 1, 20, ev(0, 0, 0,  0, 1, 1, 0));
    step("mul2_ready",  1, 1, 0, 0, 0,  1, 2, 1, 20, ev(3, 1, 12, 1, 1, 1, 0));
    step("mul2_acc",    1, 1, 0, 0, 0,  1, 2, 1, 20, ev(0, 0, 0,  0, 0, 0, 0));
    step("illegal_md",  1, 1, 1, 3, 9,  1, 2, 0, 0,  ev(0, 0, 0,  0, 0, 1, 1));
    // reset while counter==2 aborts the product
    step("rst_mid",     0, 0, 0, 0, 0,  0, 0, 0, 0,  ev(0, 0, 0,  0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      step("post_rst",  1, 0, 0, 0, 0,  0, 0, 0, 0,  ev(0, 0, 0,  0, 0, 0, 0));

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
